// File: rtl/multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state encoding
// and the number of states it uses.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_STATES = 3;

endpackage

// File: rtl/multiplier_iterative_dpath.sv
// Datapath of the iterative multiplier: operand shift registers, the accumulator
// and the iteration counter, sequenced by load/shift/add strobes from the FSM.
module multiplier_iterative_dpath
    import multiplier_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic               add_i,
    input  logic [p_nbits-1:0] in0_i,
    input  logic [p_nbits-1:0] in1_i,
    output logic               b_lsb_o,
    output logic               count_done_o,
    output logic [p_nbits-1:0] result_o
);

    localparam int CW = $clog2(p_nbits);
    localparam logic [CW-1:0] LAST_COUNT = CW'(p_nbits - 1);

    logic [p_nbits-1:0] a_q, a_d;
    logic [p_nbits-1:0] b_q, b_d;
    logic [p_nbits-1:0] result_q, result_d;
    logic [CW-1:0]      count_q, count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        count_d  = count_q;
        if (load_i) begin
            a_d      = in0_i;
            b_d      = in1_i;
            result_d = '0;
            count_d  = '0;
        end else if (shift_i) begin
            // Low bits of the product are sign-agnostic, so the carry out is simply dropped.
            if (add_i) begin
                result_d = result_q + a_q;
            end
            a_d     = a_q << 1;
            b_d     = b_q >> 1;
            count_d = count_q + CW'(1);
        end
    end

    assign b_lsb_o      = b_q[0];
    assign count_done_o = (count_q == LAST_COUNT);
    assign result_o     = result_q;

endmodule

// File: rtl/multiplier_iterative.sv
// Iterative shift-add multiplier with val/rdy streams; control FSM on top of
// the datapath, one partial product per cycle for exactly p_nbits cycles.
module multiplier_iterative
    import multiplier_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [p_nbits-1:0] out
);

    state_t state_q, state_d;
    // Holds istream_rdy low while reset is asserted and until the first edge after release.
    logic   armed_q;

    logic load;
    logic shift;
    logic add;
    logic b_lsb;
    logic count_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    assign istream_rdy = armed_q && (state_q == IDLE);
    assign ostream_val = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (istream_val && istream_rdy) begin
                    load    = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                shift = 1'b1;
                if (count_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign add = shift && b_lsb;

    multiplier_iterative_dpath #(
        .p_nbits(p_nbits)
    ) u_dpath (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load),
        .shift_i      (shift),
        .add_i        (add),
        .in0_i        (in0),
        .in1_i        (in1),
        .b_lsb_o      (b_lsb),
        .count_done_o (count_done),
        .result_o     (out)
    );

endmodule

// File: tb/tb_multiplier_iterative.sv
// Scoreboard bench for multiplier_iterative at widths 32 and 8: stimulus pushes
// expected products, a monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_multiplier_iterative;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v[2];
    logic        ordy[2];
    logic [31:0] a[2];
    logic [31:0] b[2];

    logic        rdy32, ov32;
    logic [31:0] out32;
    logic        rdy8, ov8;
    logic [7:0]  out8;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          rand_mode = 0;

    always #5 clk = ~clk;

    multiplier_iterative #(.p_nbits(32)) dut32 (
        .clk(clk), .reset(rst_n), .istream_val(v[0]), .istream_rdy(rdy32),
        .in0(a[0]), .in1(b[0]), .ostream_val(ov32), .ostream_rdy(ordy[0]), .out(out32)
    );

    multiplier_iterative #(.p_nbits(8)) dut8 (
        .clk(clk), .reset(rst_n), .istream_val(v[1]), .istream_rdy(rdy8),
        .in0(a[1][7:0]), .in1(b[1][7:0]), .ostream_val(ov8), .ostream_rdy(ordy[1]), .out(out8)
    );

    function automatic logic [31:0] mask(input int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic get_rdy(input int d);
        return (d == 0) ? rdy32 : rdy8;
    endfunction

    function automatic logic get_ov(input int d);
        return (d == 0) ? ov32 : ov8;
    endfunction

    function automatic logic [31:0] get_out(input int d);
        return (d == 0) ? out32 : {24'd0, out8};
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? exp0.size() : exp1.size();
    endfunction

    function automatic void push(input int d, input logic [31:0] e);
        if (d == 0) exp0.push_back(e);
        else exp1.push_back(e);
    endfunction

    function automatic logic [31:0] pop(input int d);
        if (d == 0) return exp0.pop_front();
        return exp1.pop_front();
    endfunction

    // Reference: plain arithmetic product truncated to the DUT width.
    function automatic logic [31:0] model(input int d, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'd0, x & mask(d)} * {32'd0, y & mask(d)};
        return p[31:0] & mask(d);
    endfunction

    function automatic logic [31:0] pick(input int d);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return mask(d);
            3: return (d == 0) ? 32'h8000_0000 : 32'h0000_0080;
            default: return $urandom & mask(d);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic step(input int d);
        @(posedge clk);
        #1;
        if (rand_mode) ordy[d] = ($urandom_range(0, 3) != 0);
    endtask

    // Offer operands until accepted; returns 1 ns after the accepting edge.
    task automatic send(input int d, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
        bit got = 0;
        v[d] = 1'b1;
        a[d] = x;
        b[d] = y;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (get_rdy(d)) begin
                got = 1;
                push(d, e);
            end
            step(d);
        end
        v[d] = 1'b0;
        if (!got) begin
            n_checks++;
            $display("FAIL accept_timeout dut%0d: istream_rdy got 0, required 1", d);
        end
    endtask

    task automatic wait_done(input int d);
        bit done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            done = get_rdy(d) && (qsize(d) == 0);
            step(d);
        end
        check($sformatf("drain_dut%0d", d), qsize(d), 0);
        check($sformatf("idle_rdy_dut%0d", d), 32'(get_rdy(d)), 1);
    endtask

    task automatic timed_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e, input string tag);
        int k = 0;
        ordy[0] = 1'b1;
        send(0, x, y, e);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (ov32) break;
        end
        check({tag, "_val_lat"}, k, 33);
        check({tag, "_out"}, out32, e);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            k++;
            if (rdy32) break;
        end
        check({tag, "_rdy_lat"}, k, 34);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                if (get_ov(d) && ordy[d]) begin
                    if (qsize(d) == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_out_dut%0d: got %h, required no output", d, get_out(d));
                    end else begin
                        logic [31:0] e;
                        e = pop(d);
                        $display("txn dut%0d out=%h exp=%h", d, get_out(d), e);
                        check($sformatf("result_dut%0d", d), get_out(d), e);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tab_a[5];
        logic [31:0] tab_b[5];
        logic [31:0] tab_e[5];
        logic [31:0] x, y;
        tab_a = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tab_b = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0007};
        tab_e = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFEB};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v[d] = 1'b0;
            ordy[d] = 1'b1;
            a[d] = '0;
            b[d] = '0;
        end
        #2;
        check("reset_rdy32", 32'(rdy32), 0);
        check("reset_val32", 32'(ov32), 0);
        check("reset_out32", out32, 0);
        check("reset_rdy8", 32'(rdy8), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_rdy32", 32'(rdy32), 1);
        check("post_reset_rdy8", 32'(rdy8), 1);

        timed_op(32'd3, 32'd4, 32'd12, "basic");
        for (int i = 0; i < 5; i++) timed_op(tab_a[i], tab_b[i], tab_e[i], $sformatf("tab%0d", i));

        // Back-pressure: result must sit untouched while the consumer stalls.
        ordy[0] = 1'b0;
        send(0, 32'd5, 32'd6, 32'd30);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ov32) break;
        end
        v[0] = 1'b1;
        a[0] = 32'd77;
        b[0] = 32'd88;
        for (int i = 0; i < 10; i++) begin
            check("bp_val", 32'(ov32), 1);
            check("bp_out", out32, 30);
            check("bp_rdy", 32'(rdy32), 0);
            @(negedge clk);
        end
        check("bp_pending", exp0.size(), 1);
        @(posedge clk);
        #1;
        v[0] = 1'b0;
        ordy[0] = 1'b1;
        wait_done(0);

        // Reset in cycle 10 of 7x9; nine iterations have accumulated 63 by then.
        send(0, 32'd7, 32'd9, 32'd63);
        repeat (9) @(posedge clk);
        #1;
        check("pre_reset_out", out32, 63);
        rst_n = 1'b0;
        exp0.delete();
        #1;
        check("mid_reset_val", 32'(ov32), 0);
        check("mid_reset_out", out32, 0);
        check("mid_reset_rdy", 32'(rdy32), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rerelease_rdy", 32'(rdy32), 1);
        timed_op(32'd2, 32'd3, 32'd6, "after_reset");

        rand_mode = 1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 50; i++) begin
                x = pick(d);
                y = pick(d);
                send(d, x, y, model(d, x, y));
            end
            rand_mode = 0;
            ordy[d] = 1'b1;
            wait_done(d);
            rand_mode = 1;
        end
        rand_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
